// File: rtl/game_sequencer.sv
// game_sequencer: central game-state controller for the bar/player game.
// Sequences IDLE -> COUNTDOWN -> PLAY <-> HIT -> OVER, owns lives, BCD score,
// difficulty (cyclesneeded) and the lives LEDs. All outputs are registered.
// Optional feature: define HIGH_SCORE_EN to keep a best-score register
// (hi_score); when undefined hi_score is tied to zero.
module game_sequencer #(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned HIT_PAUSE_TICKS = 2,
  parameter int unsigned LEVEL_UP_SCORE  = 10,
  parameter int unsigned CYC_INIT        = 6,
  parameter int unsigned CYC_MIN         = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick,
  input  logic        start,
  input  logic        collide,
  input  logic        bar_passed,
  output logic [2:0]  state,
  output logic        run,
  output logic        bar_reset,
  output logic [1:0]  lives,
  output logic [2:0]  cyclesneeded,
  output logic [15:0] score,
  output logic [2:0]  led,
  output logic [15:0] hi_score
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LVL_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_HIT       = 3'd3,
    S_OVER      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [1:0]         lives_q, lives_d;
  logic [2:0]         cyc_q, cyc_d;
  logic [15:0]        score_q, score_d;
  logic [2:0]         led_q, led_d;
  logic               run_q, run_d;
  logic               bar_reset_q, bar_reset_d;
  logic               start_q;
  logic               start_evt_c;
  logic               hit_c;

  // Saturating 4-digit packed-BCD increment.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Lives count to LED thermometer code.
  function automatic logic [2:0] thermo(input logic [1:0] n);
    logic [2:0] t;
    case (n)
      2'd3:    t = 3'b111;
      2'd2:    t = 3'b011;
      2'd1:    t = 3'b001;
      default: t = 3'b000;
    endcase
    return t;
  endfunction

  assign start_evt_c = start & ~start_q;
  assign hit_c       = tick & collide;

  // Next-state and datapath updates for every game phase.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lvl_d       = lvl_q;
    lives_d     = lives_q;
    cyc_d       = cyc_q;
    score_d     = score_q;
    bar_reset_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_evt_c) begin
          state_d     = S_COUNTDOWN;
          cnt_d       = CNT_W'(COUNTDOWN_TICKS);
          lives_d     = 2'(LIVES_INIT);
          score_d     = 16'h0000;
          lvl_d       = '0;
          cyc_d       = 3'(CYC_INIT);
          bar_reset_d = 1'b1;
        end
      end

      S_COUNTDOWN: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_PLAY: begin
        if (hit_c) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d     = lives_q - 2'd1;
            state_d     = S_HIT;
            cnt_d       = CNT_W'(HIT_PAUSE_TICKS);
            bar_reset_d = 1'b1;
          end
        end else if (bar_passed) begin
          score_d = bcd_inc(score_q);
          if (lvl_q >= LVL_W'(LEVEL_UP_SCORE - 1)) begin
            lvl_d = '0;
            if (cyc_q > 3'(CYC_MIN)) begin
              cyc_d = cyc_q - 3'd1;
            end
          end else begin
            lvl_d = lvl_q + LVL_W'(1);
          end
        end
      end

      S_HIT: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs derived from the next state so they change together with it.
  always_comb begin
    run_d = (state_d == S_PLAY);
    led_d = thermo(lives_d);
  end

  // State and datapath registers; clr restores the power-on values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lvl_q       <= '0;
      lives_q     <= 2'(LIVES_INIT);
      cyc_q       <= 3'(CYC_INIT);
      score_q     <= 16'h0000;
      led_q       <= thermo(2'(LIVES_INIT));
      run_q       <= 1'b0;
      bar_reset_q <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lvl_q       <= lvl_d;
      lives_q     <= lives_d;
      cyc_q       <= cyc_d;
      score_q     <= score_d;
      led_q       <= led_d;
      run_q       <= run_d;
      bar_reset_q <= bar_reset_d;
      start_q     <= start;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [15:0] hi_q, hi_d;
  logic        enter_over_c;

  assign enter_over_c = (state_q == S_PLAY) && (state_d == S_OVER);

  // Capture the finishing score if it beats the best so far.
  always_comb begin
    hi_d = hi_q;
    if (enter_over_c && (score_q > hi_q)) begin
      hi_d = score_q;
    end
  end

  // Best-score register, cleared only by clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      hi_q <= 16'h0000;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign hi_score = hi_q;
`else
  assign hi_score = 16'h0000;
`endif

  assign state        = state_q;
  assign run          = run_q;
  assign bar_reset    = bar_reset_q;
  assign lives        = lives_q;
  assign cyclesneeded = cyc_q;
  assign score        = score_q;
  assign led          = led_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed stimulus for game_sequencer with a scoreboard.
// Stimulus pushes hand-computed expected snapshots tagged with the sample slot
// at which they become visible; a monitor pops and compares on each negedge.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        clr, tick, start, collide, bar_passed;
  logic [2:0]  state;
  logic        run, bar_reset;
  logic [1:0]  lives;
  logic [2:0]  cyclesneeded;
  logic [15:0] score;
  logic [2:0]  led;
  logic [15:0] hi_score;

  game_sequencer dut (
    .clk          (clk),
    .clr          (clr),
    .tick         (tick),
    .start        (start),
    .collide      (collide),
    .bar_passed   (bar_passed),
    .state        (state),
    .run          (run),
    .bar_reset    (bar_reset),
    .lives        (lives),
    .cyclesneeded (cyclesneeded),
    .score        (score),
    .led          (led),
    .hi_score     (hi_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          slot;
    logic [2:0]  st;
    logic        rn;
    logic        br;
    logic [1:0]  lv;
    logic [2:0]  cy;
    logic [15:0] sc;
    logic [2:0]  ld;
    logic [15:0] hi;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          ncnt     = 0;
  int          due      = 0;
  int          br_seen  = 0;
  int          br_exp   = 0;
  logic [15:0] hi_exp;

  // Apply one cycle of inputs; results are visible two negedges later.
  task automatic cyc(input logic c, input logic t, input logic s,
                     input logic co, input logic bp);
    @(posedge clk);
    #1;
    clr = c; tick = t; start = s; collide = co; bar_passed = bp;
    due = ncnt + 2;
  endtask

  task automatic expect_s(input string nm, input logic [2:0] st, input logic rn,
                          input logic br, input logic [1:0] lv, input logic [2:0] cy,
                          input logic [15:0] sc, input logic [2:0] ld,
                          input logic [15:0] hi);
    exp_t e;
    e.name = nm; e.slot = due; e.st = st; e.rn = rn; e.br = br; e.lv = lv;
    e.cy = cy; e.sc = sc; e.ld = ld; e.hi = hi;
    sb_q.push_back(e);
    if (br) br_exp++;
  endtask

  // Monitor: count bar_reset pulses and compare due snapshots.
  always @(negedge clk) begin
    ncnt++;
    if (bar_reset === 1'b1) br_seen++;
    while (sb_q.size() > 0 && sb_q[0].slot <= ncnt) begin
      mon_e = sb_q.pop_front();
      n_assert++;
      if (mon_e.slot != ncnt || state !== mon_e.st || run !== mon_e.rn ||
          bar_reset !== mon_e.br || lives !== mon_e.lv || cyclesneeded !== mon_e.cy ||
          score !== mon_e.sc || led !== mon_e.ld || hi_score !== mon_e.hi) begin
        n_fail++;
        $display("FAIL %s: got st=%0d run=%b br=%b lives=%0d cyc=%0d score=%h led=%b hi=%h | want st=%0d run=%b br=%b lives=%0d cyc=%0d score=%h led=%b hi=%h",
                 mon_e.name, state, run, bar_reset, lives, cyclesneeded, score, led, hi_score,
                 mon_e.st, mon_e.rn, mon_e.br, mon_e.lv, mon_e.cy, mon_e.sc, mon_e.ld, mon_e.hi);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; tick = 1'b0; start = 1'b0; collide = 1'b0; bar_passed = 1'b0;
    hi_exp = 16'h0000;

    // Reset and first game start
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    expect_s("reset", 3'd0, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 0, 0, 0, 0);
    expect_s("idle_no_start", 3'd0, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 0, 1, 0, 0);
    expect_s("start", 3'd1, 0, 1, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);

    // Countdown ignores bar_passed and collide
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    expect_s("cd_ignore_bp", 3'd1, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 1, 0, 1, 0);
    expect_s("cd_ignore_collide", 3'd1, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 1, 0, 0, 0);
    expect_s("play_entry", 3'd2, 1, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);

    // Scoring and difficulty steps
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    expect_s("pass9", 3'd2, 1, 0, 2'd3, 3'd6, 16'h0009, 3'b111, hi_exp);
    cyc(0, 0, 0, 0, 1);
    expect_s("pass10", 3'd2, 1, 0, 2'd3, 3'd5, 16'h0010, 3'b111, hi_exp);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, 1);
    expect_s("pass60", 3'd2, 1, 0, 2'd3, 3'd1, 16'h0060, 3'b111, hi_exp);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    expect_s("pass70_floor", 3'd2, 1, 0, 2'd3, 3'd1, 16'h0070, 3'b111, hi_exp);

    // Collide without tick, then a real hit and pause
    cyc(0, 0, 0, 1, 0);
    expect_s("collide_no_tick", 3'd2, 1, 0, 2'd3, 3'd1, 16'h0070, 3'b111, hi_exp);
    cyc(0, 1, 0, 1, 0);
    expect_s("hit1", 3'd3, 0, 1, 2'd2, 3'd1, 16'h0070, 3'b011, hi_exp);
    cyc(0, 0, 0, 0, 1);
    expect_s("hit_ignore_bp", 3'd3, 0, 0, 2'd2, 3'd1, 16'h0070, 3'b011, hi_exp);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    expect_s("hit_resume", 3'd2, 1, 0, 2'd2, 3'd1, 16'h0070, 3'b011, hi_exp);

    // BCD carry and saturation
    for (int i = 0; i < 29; i++) cyc(0, 0, 0, 0, 1);
    expect_s("score_0099", 3'd2, 1, 0, 2'd2, 3'd1, 16'h0099, 3'b011, hi_exp);
    cyc(0, 0, 0, 0, 1);
    expect_s("score_0100", 3'd2, 1, 0, 2'd2, 3'd1, 16'h0100, 3'b011, hi_exp);
    for (int i = 0; i < 9899; i++) cyc(0, 0, 0, 0, 1);
    expect_s("score_9999", 3'd2, 1, 0, 2'd2, 3'd1, 16'h9999, 3'b011, hi_exp);
    cyc(0, 0, 0, 0, 1);
    expect_s("score_sat", 3'd2, 1, 0, 2'd2, 3'd1, 16'h9999, 3'b011, hi_exp);

    // Hit and pass together: hit wins
    cyc(0, 1, 0, 1, 1);
    expect_s("hit_and_pass", 3'd3, 0, 1, 2'd1, 3'd1, 16'h9999, 3'b001, hi_exp);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    expect_s("hit2_resume", 3'd2, 1, 0, 2'd1, 3'd1, 16'h9999, 3'b001, hi_exp);

    // Last life lost
    cyc(0, 1, 0, 1, 0);
`ifdef HIGH_SCORE_EN
    hi_exp = 16'h9999;
`endif
    expect_s("over", 3'd4, 0, 0, 2'd0, 3'd1, 16'h9999, 3'b000, hi_exp);
    cyc(0, 1, 0, 1, 1);
    expect_s("over_hold", 3'd4, 0, 0, 2'd0, 3'd1, 16'h9999, 3'b000, hi_exp);

    // New game from OVER; held start does not retrigger
    cyc(0, 0, 1, 0, 0);
    expect_s("restart", 3'd1, 0, 1, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 0, 1, 0, 0);
    expect_s("start_held", 3'd1, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    expect_s("play2", 3'd2, 1, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0);
    expect_s("g2_hit1", 3'd3, 0, 1, 2'd2, 3'd6, 16'h0003, 3'b011, hi_exp);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    expect_s("g2_hit2", 3'd3, 0, 1, 2'd1, 3'd6, 16'h0003, 3'b001, hi_exp);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    expect_s("over2_hi_kept", 3'd4, 0, 0, 2'd0, 3'd6, 16'h0003, 3'b000, hi_exp);

    // clr in PLAY beats a simultaneous hit; held start needs release
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_s("start3", 3'd1, 0, 1, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
    hi_exp = 16'h0000;
    expect_s("clr_mid", 3'd0, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 0, 1, 0, 0);
    expect_s("held_after_clr", 3'd0, 0, 0, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_s("press_after_release", 3'd1, 0, 1, 2'd3, 3'd6, 16'h0000, 3'b111, hi_exp);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Drain and final bookkeeping
    repeat (3) @(negedge clk);
    #1;
    n_assert++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end
    n_assert++;
    if (br_seen != br_exp) begin
      n_fail++;
      $display("FAIL bar_reset_count: got %0d pulses, want %0d", br_seen, br_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
